// File: rtl/ehr_mode_fifo.sv
// FIFO with EHR-style enq/deq ordering chosen by MODE (0 pipeline, 1 bypass, 2 conflict-free).
// Optional occupancy port `count` is built only when EHR_FIFO_COUNT_EN is defined.
module ehr_mode_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int MODE  = 0
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] enq_x,
  input  logic             EN_enq,
  output logic             RDY_enq,
  output logic [WIDTH-1:0] first,
  output logic             RDY_first,
  input  logic             EN_deq,
  output logic             RDY_deq,
  input  logic             EN_clear,
  output logic             RDY_clear
`ifdef EHR_FIFO_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    enq_ptr_reg, deq_ptr_reg;
  logic [PW-1:0]    enq_ptr_next, deq_ptr_next;
  logic             empty_reg, full_reg;
  logic             do_enq, do_deq;

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    enq_ptr_next = (enq_ptr_reg == LAST) ? '0 : enq_ptr_reg + PW'(1);
    deq_ptr_next = (deq_ptr_reg == LAST) ? '0 : deq_ptr_reg + PW'(1);
  end

  generate
    if (MODE == 0) begin : g_pipeline
      always_comb begin
        RDY_enq = !full_reg || EN_deq;
        RDY_deq = !empty_reg;
        first   = mem[deq_ptr_reg];
      end
    end else if (MODE == 1) begin : g_bypass
      always_comb begin
        RDY_enq = !full_reg;
        RDY_deq = !empty_reg || EN_enq;
        first   = empty_reg ? enq_x : mem[deq_ptr_reg];
      end
    end else begin : g_cf
      always_comb begin
        RDY_enq = !full_reg;
        RDY_deq = !empty_reg;
        first   = mem[deq_ptr_reg];
      end
    end
  endgenerate

  assign RDY_first = RDY_deq;
  assign RDY_clear = 1'b1;
  assign do_enq    = EN_enq && RDY_enq;
  assign do_deq    = EN_deq && RDY_deq;

  // Storage is not reset; contents are only observed through valid slots.
  always_ff @(posedge CLK) begin
    if (do_enq) mem[enq_ptr_reg] <= enq_x;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || EN_clear) begin
      enq_ptr_reg <= '0;
      deq_ptr_reg <= '0;
      empty_reg   <= 1'b1;
      full_reg    <= 1'b0;
    end else begin
      if (do_enq) enq_ptr_reg <= enq_ptr_next;
      if (do_deq) deq_ptr_reg <= deq_ptr_next;
      if (do_enq && !do_deq) begin
        empty_reg <= 1'b0;
        full_reg  <= (enq_ptr_next == deq_ptr_reg);
      end else if (do_deq && !do_enq) begin
        full_reg  <= 1'b0;
        empty_reg <= (deq_ptr_next == enq_ptr_reg);
      end
    end
  end

`ifdef EHR_FIFO_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] count_reg;

  always_ff @(posedge CLK) begin
    if (!RST_N || EN_clear) begin
      count_reg <= '0;
    end else if (do_enq && !do_deq) begin
      count_reg <= count_reg + 1'b1;
    end else if (do_deq && !do_enq) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
`endif

endmodule

// File: tb/tb_ehr_mode_fifo.sv
// Bench for ehr_mode_fifo: five instances (modes/depths below) checked against a queue scoreboard.
module tb_ehr_mode_fifo;

  localparam int NI = 5;
  // index:                      4     3     2     1     0
  localparam bit [NI-1:0][1:0] MODES  = {2'd0, 2'd0, 2'd2, 2'd1, 2'd0};
  localparam bit [NI-1:0][1:0] DEPTHS = {2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  logic       CLK = 1'b0;
  logic       rst_n;
  logic [7:0] enq_x    [NI];
  logic       en_enq   [NI];
  logic       en_deq   [NI];
  logic       en_clear [NI];
  logic       rdy_enq  [NI];
  logic [7:0] first_w  [NI];
  logic       rdy_first[NI];
  logic       rdy_deq  [NI];
  logic       rdy_clear[NI];
  logic [1:0] count_w  [NI];

  logic [7:0] sb[NI][$];
  int compared   = 0;
  int mismatched = 0;

  always #5 CLK = ~CLK;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CW = $clog2(int'(DEPTHS[gi]) + 1);
    ehr_mode_fifo #(.WIDTH(8), .DEPTH(int'(DEPTHS[gi])), .MODE(int'(MODES[gi]))) u_dut (
      .CLK      (CLK),
      .RST_N    (rst_n),
      .enq_x    (enq_x[gi]),
      .EN_enq   (en_enq[gi]),
      .RDY_enq  (rdy_enq[gi]),
      .first    (first_w[gi]),
      .RDY_first(rdy_first[gi]),
      .EN_deq   (en_deq[gi]),
      .RDY_deq  (rdy_deq[gi]),
      .EN_clear (en_clear[gi]),
      .RDY_clear(rdy_clear[gi])
`ifdef EHR_FIFO_COUNT_EN
      ,
      .count    (count_w[gi][CW-1:0])
`endif
    );
    if (CW < 2) begin : g_pad
      assign count_w[gi][1] = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < NI; i++) begin
      enq_x[i] = 8'h00; en_enq[i] = 1'b0; en_deq[i] = 1'b0; en_clear[i] = 1'b0;
    end
  endtask

  task automatic drive(input int i, input bit en, input logic [7:0] x, input bit dq, input bit clr);
    en_enq[i] = en; enq_x[i] = x; en_deq[i] = dq; en_clear[i] = clr;
  endtask

  // Check every instance against the model, then clock once and update the scoreboard.
  task automatic tick();
    bit e[NI];
    bit d[NI];
    int occ;
    bit re, rd;
    logic [7:0] exp_first;
    logic [7:0] got;
    #1;
    for (int i = 0; i < NI; i++) begin
      occ = sb[i].size();
      re  = (occ < int'(DEPTHS[i])) || (MODES[i] == 2'd0 && en_deq[i]);
      rd  = (occ > 0) || (MODES[i] == 2'd1 && en_enq[i]);
      e[i] = en_enq[i] && re;
      d[i] = en_deq[i] && rd;
      if (rst_n) begin
        chk($sformatf("rdy_enq[%0d]", i), 32'(rdy_enq[i]), 32'(re));
        chk($sformatf("rdy_deq[%0d]", i), 32'(rdy_deq[i]), 32'(rd));
        chk($sformatf("rdy_first[%0d]", i), 32'(rdy_first[i]), 32'(rd));
        chk($sformatf("rdy_clear[%0d]", i), 32'(rdy_clear[i]), 32'd1);
`ifdef EHR_FIFO_COUNT_EN
        chk($sformatf("count[%0d]", i), 32'(count_w[i]), 32'(occ));
`endif
        if (rd) begin
          exp_first = (occ > 0) ? sb[i][0] : enq_x[i];
          chk($sformatf("first[%0d]", i), 32'(first_w[i]), 32'(exp_first));
        end
      end
    end
    @(posedge CLK);
    for (int i = 0; i < NI; i++) begin
      if (!rst_n || en_clear[i]) begin
        sb[i].delete();
      end else begin
        if (e[i]) begin
          sb[i].push_back(enq_x[i]);
          $display("t=%0t inst%0d enq %02h", $time, i, enq_x[i]);
        end
        if (d[i]) begin
          got = sb[i].pop_front();
          $display("t=%0t inst%0d deq %02h", $time, i, got);
        end
      end
    end
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();  // reset-state check

    // Fill all instances with 11,22,33, overflow attempt, drain.
    for (int k = 0; k < 3; k++) begin
      idle();
      for (int i = 0; i < NI; i++) drive(i, 1'b1, 8'(8'h11 * (k + 1)), 1'b0, 1'b0);
      tick();
    end
    idle();
    for (int i = 0; i < NI; i++) drive(i, 1'b1, 8'h99, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 3; k++) begin
      idle();
      for (int i = 0; i < NI; i++) drive(i, 1'b0, 8'h00, 1'b1, 1'b0);
      tick();
    end
    idle(); tick();

    // Pipeline depth 2: full, simultaneous enq+deq.
    idle(); drive(3, 1'b1, 8'h11, 1'b0, 1'b0); tick();
    idle(); drive(3, 1'b1, 8'h22, 1'b0, 1'b0); tick();
    idle(); drive(3, 1'b1, 8'h44, 1'b1, 1'b0); tick();
    idle(); drive(3, 1'b0, 8'h00, 1'b1, 1'b0); tick();
    idle(); drive(3, 1'b0, 8'h00, 1'b1, 1'b0); tick();
    idle(); tick();

    // Bypass pass-through on empty.
    idle(); drive(1, 1'b1, 8'h55, 1'b1, 1'b0); tick();
    idle(); tick();

    // Conflict-free: deq ignored when empty, enq ignored when full.
    idle(); drive(2, 1'b1, 8'h66, 1'b1, 1'b0); tick();
    idle(); drive(2, 1'b1, 8'h77, 1'b0, 1'b0); tick();
    idle(); drive(2, 1'b1, 8'h88, 1'b0, 1'b0); tick();
    idle(); drive(2, 1'b1, 8'hAA, 1'b1, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      idle(); drive(2, 1'b0, 8'h00, 1'b1, 1'b0); tick();
    end

    // Wrap-around traffic on the three depth-3 instances.
    for (int k = 0; k < 20; k++) begin
      idle();
      for (int i = 0; i < 3; i++) drive(i, (k % 3) != 2, 8'(k * 7 + 1), (k % 2) == 1, 1'b0);
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      for (int i = 0; i < 3; i++) drive(i, 1'b0, 8'h00, 1'b1, 1'b0);
      tick();
    end

    // Clear together with enq.
    idle(); drive(0, 1'b1, 8'hC1, 1'b0, 1'b0); drive(3, 1'b1, 8'hC1, 1'b0, 1'b0); tick();
    idle(); drive(0, 1'b1, 8'hC2, 1'b0, 1'b0); drive(3, 1'b1, 8'hC2, 1'b0, 1'b0); tick();
    idle(); drive(0, 1'b1, 8'hC3, 1'b0, 1'b1); drive(3, 1'b1, 8'hC3, 1'b1, 1'b1); tick();
    idle(); tick();

    // Reset in the middle of traffic.
    idle();
    for (int i = 0; i < NI; i++) drive(i, 1'b1, 8'h5A, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < NI; i++) drive(i, 1'b1, 8'h5B, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(); tick();
    idle(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
